// File: rtl/rom_fetcher_pkg.sv
// rtl/rom_fetcher_pkg.sv - shared types and default parameters for the ROM burst fetcher
package rom_fetcher_pkg;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_SIZE  = 4;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/rom_fetcher_sync_fifo.sv
// rtl/rom_fetcher_sync_fifo.sv - synchronous FIFO buffering fetched words with their addresses
module sync_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // A push into a full FIFO is only accepted when a pop frees the slot in the same cycle
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

  // Storage array: data only, no reset needed since validity is tracked by the count
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));

endmodule

// File: rtl/rom_fetcher.sv
// rtl/rom_fetcher.sv - burst reader driving a synchronous ROM into a ready/valid output FIFO
module rom_fetcher
  import rom_fetcher_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_SIZE  = DEF_DATA_SIZE,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   start_addr,
  input  logic [ADDR_WIDTH:0]     count,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   rom_addr,
  input  logic [8*DATA_SIZE-1:0]  rom_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*DATA_SIZE-1:0]  out_data,
  output logic [ADDR_WIDTH-1:0]   out_addr
);

  localparam int DW   = 8 * DATA_SIZE;
  localparam int FW   = DW + ADDR_WIDTH;
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
  localparam int OCCW = CNTW + 1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_rom_addr;
  logic [ADDR_WIDTH-1:0] w_rom_addr_nxt;
  logic [ADDR_WIDTH:0]   r_remaining;

  // Two-stage tracker: stage 1 = address presented to ROM, stage 2 = ROM data arriving now
  logic                  r_p1_valid;
  logic [ADDR_WIDTH-1:0] r_p1_addr;
  logic                  r_p2_valid;
  logic [ADDR_WIDTH-1:0] r_p2_addr;

  logic                  w_issue_first;
  logic                  w_issue_next;
  logic                  w_issue;
  logic [OCCW-1:0]       w_occupancy;
  logic                  w_room;
  logic                  w_drained;
  logic                  w_pop;
  logic                  w_push;
  logic [FW-1:0]         w_push_data;
  logic [FW-1:0]         w_head;
  logic [CNTW-1:0]       w_fifo_count;
  logic                  w_fifo_empty;
  logic                  w_fifo_full;

  // Buffered words plus words still in the ROM pipeline must fit, so the FIFO can never overflow
  assign w_occupancy = OCCW'(w_fifo_count) + OCCW'(r_p1_valid) + OCCW'(r_p2_valid);
  assign w_room      = !w_fifo_full && (w_occupancy < OCCW'(FIFO_DEPTH));
  assign w_pop       = out_valid && out_ready;
  assign w_push      = r_p2_valid;
  assign w_push_data = {r_p2_addr, rom_data};

  // Burst is over once nothing is in flight and the FIFO empties, counting a last pop this cycle
  assign w_drained = !r_p1_valid && !r_p2_valid &&
                     (w_fifo_empty || ((w_fifo_count == CNTW'(1)) && w_pop));

  assign w_issue = w_issue_first || w_issue_next;

  // Next-state and issue decisions
  always_comb begin
    w_state_nxt   = r_state;
    w_issue_first = 1'b0;
    w_issue_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (count == '0) begin
            w_state_nxt = ST_FINISH;
          end else begin
            w_issue_first = 1'b1;
            w_state_nxt   = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (r_remaining == '0) begin
          w_state_nxt = ST_DRAIN;
        end else if (w_room) begin
          w_issue_next = 1'b1;
          if (r_remaining == (ADDR_WIDTH+1)'(1)) begin
            w_state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (w_drained) begin
          w_state_nxt = ST_FINISH;
        end
      end
      ST_FINISH: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Address of the word being issued this cycle; held when nothing is issued
  always_comb begin
    w_rom_addr_nxt = r_rom_addr;
    if (w_issue_first) begin
      w_rom_addr_nxt = start_addr;
    end else if (w_issue_next) begin
      w_rom_addr_nxt = r_rom_addr + ADDR_WIDTH'(1);
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Issue counter, ROM address register and in-flight pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rom_addr  <= '0;
      r_remaining <= '0;
      r_p1_valid  <= 1'b0;
      r_p1_addr   <= '0;
      r_p2_valid  <= 1'b0;
      r_p2_addr   <= '0;
    end else begin
      r_rom_addr <= w_rom_addr_nxt;
      if (w_issue_first) begin
        r_remaining <= count - (ADDR_WIDTH+1)'(1);
      end else if (w_issue_next) begin
        r_remaining <= r_remaining - (ADDR_WIDTH+1)'(1);
      end
      r_p1_valid <= w_issue;
      r_p1_addr  <= w_rom_addr_nxt;
      r_p2_valid <= r_p1_valid;
      r_p2_addr  <= r_p1_addr;
    end
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_FINISH);
  assign rom_addr  = r_rom_addr;
  assign out_valid = !w_fifo_empty;
  assign out_data  = w_head[DW-1:0];
  assign out_addr  = w_head[FW-1:DW];

endmodule
